// File: rtl/mvm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mvm_ctrl
//  Description : Control FSM for the matrix-vector multiply datapath. Steers
//                an input word stream into the KxK matrix and K-entry vector
//                memories, sequences the per-row multiply-accumulate and
//                releases each row result over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module mvm_ctrl #(
    parameter int K    = 4,
    parameter int LOGK = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic                new_matrix,
    output logic                wr_en_m,
    output logic [2*LOGK-1:0]   addr_m,
    output logic                wr_en_x,
    output logic [LOGK-1:0]     addr_x,
    output logic [LOGK-1:0]     rd_row,
    output logic [LOGK-1:0]     rd_col,
    output logic                mac_en,
    output logic                mac_clr,
    output logic                m_valid,
    input  logic                m_ready
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_LOAD_M  = 3'd1;
    localparam logic [2:0] c_LOAD_X  = 3'd2;
    localparam logic [2:0] c_COMPUTE = 3'd3;
    localparam logic [2:0] c_OUT     = 3'd4;

    localparam logic [2*LOGK-1:0] c_CNT_ONE    = (2*LOGK)'(1);
    localparam logic [2*LOGK-1:0] c_CNT_LAST_M = (2*LOGK)'(K*K-1);
    localparam logic [2*LOGK-1:0] c_CNT_LAST_X = (2*LOGK)'(K-1);
    localparam logic [LOGK-1:0]   c_IDX_ONE    = LOGK'(1);
    localparam logic [LOGK-1:0]   c_IDX_LAST   = LOGK'(K-1);

    logic [2:0]          r_state;
    logic [2*LOGK-1:0]   r_cnt;
    logic [LOGK-1:0]     r_row;
    logic [LOGK-1:0]     r_col;
    logic                r_mat_loaded;
    logic                w_accept;
    logic                w_to_matrix;

    // A first word goes to the matrix when asked, or when no matrix exists yet
    assign w_to_matrix = new_matrix || !r_mat_loaded;
    assign w_accept    = s_valid && s_ready;

    // Output decode: strobes/addresses follow state, cnt and s_valid; all quiet in reset
    always_comb begin
        s_ready = 1'b0;
        wr_en_m = 1'b0;
        addr_m  = '0;
        wr_en_x = 1'b0;
        addr_x  = '0;
        rd_row  = '0;
        rd_col  = '0;
        mac_en  = 1'b0;
        mac_clr = 1'b0;
        m_valid = 1'b0;
        if (!reset) begin
            rd_row = r_row;
            rd_col = r_col;
            case (r_state)
                c_IDLE: begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        if (w_to_matrix) begin
                            wr_en_m = 1'b1;
                        end else begin
                            wr_en_x = 1'b1;
                        end
                    end
                end
                c_LOAD_M: begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        wr_en_m = 1'b1;
                        addr_m  = r_cnt;
                    end
                end
                c_LOAD_X: begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        wr_en_x = 1'b1;
                        addr_x  = r_cnt[LOGK-1:0];
                    end
                end
                c_COMPUTE: begin
                    mac_en  = 1'b1;
                    mac_clr = (r_col == '0);
                end
                c_OUT: begin
                    m_valid = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sequencer: load matrix/vector, then MAC one row at a time and hand off
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_cnt        <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_mat_loaded <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= c_CNT_ONE;
                        r_state <= w_to_matrix ? c_LOAD_M : c_LOAD_X;
                    end
                end
                c_LOAD_M: begin
                    if (w_accept) begin
                        if (r_cnt == c_CNT_LAST_M) begin
                            r_mat_loaded <= 1'b1;
                            r_cnt        <= '0;
                            r_state      <= c_LOAD_X;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                end
                c_LOAD_X: begin
                    if (w_accept) begin
                        if (r_cnt == c_CNT_LAST_X) begin
                            r_cnt   <= '0;
                            r_row   <= '0;
                            r_col   <= '0;
                            r_state <= c_COMPUTE;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                end
                c_COMPUTE: begin
                    if (r_col == c_IDX_LAST) begin
                        r_col   <= '0;
                        r_state <= c_OUT;
                    end else begin
                        r_col <= r_col + c_IDX_ONE;
                    end
                end
                c_OUT: begin
                    if (m_ready) begin
                        if (r_row == c_IDX_LAST) begin
                            r_row   <= '0;
                            r_state <= c_IDLE;
                        end else begin
                            r_row   <= r_row + c_IDX_ONE;
                            r_state <= c_COMPUTE;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mvm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mvm_ctrl
//  Description : Self-checking bench for mvm_ctrl. A transaction-level model
//                predicts every output each cycle; directed scenarios add
//                hand-computed totals, followed by randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mvm_ctrl;

    localparam int K    = 4;
    localparam int LOGK = 2;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic                new_matrix = 1'b0;
    logic                wr_en_m;
    logic [2*LOGK-1:0]   addr_m;
    logic                wr_en_x;
    logic [LOGK-1:0]     addr_x;
    logic [LOGK-1:0]     rd_row;
    logic [LOGK-1:0]     rd_col;
    logic                mac_en;
    logic                mac_clr;
    logic                m_valid;
    logic                m_ready = 1'b1;

    mvm_ctrl #(.K(K), .LOGK(LOGK)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .new_matrix (new_matrix),
        .wr_en_m    (wr_en_m),
        .addr_m     (addr_m),
        .wr_en_x    (wr_en_x),
        .addr_x     (addr_x),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .mac_en     (mac_en),
        .mac_clr    (mac_clr),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    // Transaction model: what part of the job is in progress, not how the RTL encodes it
    int phase    = 0;   // 0 waiting for job, 1 taking matrix, 2 taking vector, 3 MAC, 4 result
    bit have_mat = 1'b0;
    int nwords   = 0;   // words already taken in the current load
    int row      = 0;
    int step     = 0;   // MAC products already taken for the current row

    // Totals derived from the model, pinned by literal expectations
    int n_wm, n_wx, n_mac, n_clr, n_res, lat, last_acc;
    bit lat_pend;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic clr_tally();
        n_wm = 0; n_wx = 0; n_mac = 0; n_clr = 0; n_res = 0; lat = -1; lat_pend = 1'b0;
    endtask

    // One clock: drive inputs, compare against model prediction, advance the model
    task automatic tick(input bit rst, input bit sv, input bit nm, input bit mr);
        bit e_rdy, e_wm, e_wx, e_mac, e_clr, e_mv;
        int e_am, e_ax, e_row, e_col;
        @(negedge clk);
        reset = rst; s_valid = sv; new_matrix = nm; m_ready = mr;
        #1;
        e_rdy = 0; e_wm = 0; e_wx = 0; e_mac = 0; e_clr = 0; e_mv = 0;
        e_am = 0; e_ax = 0; e_row = 0; e_col = 0;
        if (!rst) begin
            if (phase <= 2) e_rdy = 1;
            if (phase == 0 && sv) begin
                if (nm || !have_mat) e_wm = 1; else e_wx = 1;
            end
            if (phase == 1 && sv) begin e_wm = 1; e_am = nwords; end
            if (phase == 2 && sv) begin e_wx = 1; e_ax = nwords; end
            if (phase == 3) begin
                e_mac = 1; e_clr = (step == 0); e_row = row; e_col = step;
            end
            if (phase == 4) begin e_mv = 1; e_row = row; end
        end
        check("s_ready", s_ready, e_rdy);
        check("wr_en_m", wr_en_m, e_wm);
        check("addr_m",  addr_m,  e_am);
        check("wr_en_x", wr_en_x, e_wx);
        check("addr_x",  addr_x,  e_ax);
        check("rd_row",  rd_row,  e_row);
        check("rd_col",  rd_col,  e_col);
        check("mac_en",  mac_en,  e_mac);
        check("mac_clr", mac_clr, e_clr);
        check("m_valid", m_valid, e_mv);
        n_wm += e_wm; n_wx += e_wx; n_mac += e_mac; n_clr += e_clr;
        if (e_mv && mr) n_res++;
        if (e_mv && lat_pend) begin lat = cyc - last_acc; lat_pend = 0; end
        if (rst) begin
            phase = 0; have_mat = 0; nwords = 0; row = 0; step = 0;
        end else begin
            case (phase)
                0: if (sv) begin phase = (nm || !have_mat) ? 1 : 2; nwords = 1; end
                1: if (sv) begin
                       nwords++;
                       if (nwords == K*K) begin have_mat = 1; phase = 2; nwords = 0; end
                   end
                2: if (sv) begin
                       nwords++;
                       if (nwords == K) begin
                           phase = 3; row = 0; step = 0; last_acc = cyc; lat_pend = 1;
                       end
                   end
                3: begin
                       step++;
                       if (step == K) begin step = 0; phase = 4; end
                   end
                4: if (mr) begin
                       if (row == K-1) phase = 0; else begin row++; phase = 3; end
                   end
                default: phase = 0;
            endcase
        end
        cyc++;
    endtask

    // Run with idle inputs until the job finishes; bp_cycles of m_ready=0 on row 1
    task automatic drain(input int bp_cycles, output int held);
        int n;
        held = 0;
        n = 0;
        while (phase != 0 && n < 300) begin
            if (phase == 4 && row == 1 && held < bp_cycles) begin
                tick(0, 0, 0, 0);
                held++;
            end else begin
                tick(0, 0, 0, 1);
            end
            n++;
        end
        if (phase != 0) check("drain_timeout", phase, 0);
    endtask

    initial begin
        int held, n;
        // Reset and idle state
        tick(1, 0, 0, 1);
        tick(1, 1, 1, 1);
        check("rst_s_ready_low", s_ready, 0);
        tick(0, 0, 0, 1);
        check("post_rst_s_ready", s_ready, 1);
        check("post_rst_m_valid", m_valid, 0);

        // Full load: 16 matrix words then 4 vector words back to back
        clr_tally();
        for (int i = 0; i < K*K + K; i++) tick(0, 1, (i == 0), 1);
        drain(0, held);
        check("full_wr_m_count", n_wm, 16);
        check("full_wr_x_count", n_wx, 4);
        check("full_mac_count",  n_mac, 16);
        check("full_clr_count",  n_clr, 4);
        check("full_latency",    lat, 5);
        check("full_results",    n_res, 4);

        // Vector reuse with gaps in s_valid, then backpressure on row 1
        clr_tally();
        for (int i = 0; i < 2*K; i++) tick(0, (i % 2 == 0), 0, 1);
        drain(10, held);
        check("reuse_wr_m_count", n_wm, 0);
        check("reuse_wr_x_count", n_wx, 4);
        check("reuse_results",    n_res, 4);
        check("bp_hold_cycles",   held, 10);

        // Reset during COMPUTE of row 2
        for (int i = 0; i < K; i++) tick(0, 1, 0, 1);
        n = 0;
        while (!(phase == 3 && row == 2) && n < 100) begin tick(0, 0, 0, 1); n++; end
        check("reach_row2", row, 2);
        tick(1, 0, 0, 1);
        tick(0, 0, 0, 1);
        check("midrst_s_ready", s_ready, 1);
        check("midrst_m_valid", m_valid, 0);
        check("midrst_mac_en",  mac_en, 0);
        clr_tally();
        for (int i = 0; i < K*K + K; i++) tick(0, 1, 0, 1);
        drain(0, held);
        check("forced_wr_m_count", n_wm, 16);
        check("forced_results",    n_res, 4);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            tick(($urandom % 300) == 0, ($urandom % 10) < 6, ($urandom % 4) == 0,
                 ($urandom % 10) < 7);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mvm_ctrl.md
# mvm_ctrl

Control FSM for the matrix-vector multiply (MVM) datapath. It accepts a stream of input words over a valid/ready handshake and steers them into the matrix (K×K) and vector (K) register memories. It then sequences the multiply-accumulate over every row and releases each row result over a second valid/ready handshake. The controller carries no data: `s_data` feeds the memories' `data_in` directly, and the datapath's read muxes and accumulator take their control from this block.

## Interface
Parameters:
- `K`, default 4: matrix/vector dimension; must be a power of two, ≥2.
- `LOGK`, default 2: log2(K).

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `s_valid`, in, 1: an input word is present.
- `s_ready`, out, 1: controller can accept a word.
- `new_matrix`, in, 1: sampled only on the first word of a transaction; 1 means a matrix load precedes the vector.
- `wr_en_m`, out, 1: write strobe for the matrix memory.
- `addr_m`, out, 2*LOGK: matrix write address, equal to {row, col}.
- `wr_en_x`, out, 1: write strobe for the vector memory.
- `addr_x`, out, LOGK: vector write address.
- `rd_row`, out, LOGK: row select for the matrix read mux.
- `rd_col`, out, LOGK: column select for the matrix and vector read muxes.
- `mac_en`, out, 1: accumulator updates this cycle.
- `mac_clr`, out, 1: when `mac_en` is also high, the accumulator loads the product instead of adding it.
- `m_valid`, out, 1: accumulator holds a finished row result.
- `m_ready`, in, 1: downstream accepts the result.

## Operation
- **States:** IDLE, LOAD_M, LOAD_X, COMPUTE, OUT.
- **Internal state:** `cnt` (2*LOGK bits), `row`, `col`, and flag `mat_loaded`.
- **Accept:** a word is accepted when `s_valid && s_ready`.
- **`s_ready`:** 1 in IDLE, LOAD_M and LOAD_X; 0 in COMPUTE and OUT; forced 0 while `reset` is high.
- **IDLE, accept with `new_matrix` || !`mat_loaded`:**
  - Write the word to the matrix memory: `wr_en_m`=1, `addr_m`=0.
  - Set `cnt`=1 and go to LOAD_M.
  - A word with `new_matrix`=0 before any matrix has ever been loaded is treated as a matrix load.
- **IDLE, accept otherwise:** write `wr_en_x`=1, `addr_x`=0; set `cnt`=1 and go to LOAD_X.
- **LOAD_M:**
  - Each accept writes `addr_m`=`cnt`, then `cnt`++.
  - On the accept with `cnt`=K*K-1: set `mat_loaded`=1, clear `cnt`, go to LOAD_X.
- **LOAD_X:**
  - Each accept writes `addr_x`=`cnt`[LOGK-1:0], then `cnt`++.
  - On the accept with `cnt`=K-1: clear `row`/`col`, go to COMPUTE.
- **Idle cycles:** when no word is accepted, no write strobe is asserted and the counters hold.
- **COMPUTE:**
  - `mac_en`=1 every cycle; `mac_clr`=(`col`==0); `rd_row`=`row`; `rd_col`=`col`.
  - `col` increments each cycle.
  - On `col`==K-1: wrap `col` to 0 and go to OUT.
- **OUT:**
  - `m_valid`=1, `mac_en`=0; `rd_row`/`rd_col` hold.
  - On `m_ready`:
    - If `row`==K-1: `row`=0, go to IDLE.
    - Otherwise: `row`++, go to COMPUTE.
  - Without `m_ready`: hold indefinitely.
- **Transactions do not overlap:** no input is accepted until all K results have been taken.
- **`mat_loaded`:** cleared only by reset. The matrix persists across vector-only transactions.

## Timing
- **Reset:**
  - Takes effect at the first rising edge with `reset`=1.
  - Afterwards: state=IDLE, `cnt`/`row`/`col`=0, `mat_loaded`=0.
  - All outputs 0 while `reset` is high, including `s_ready`.
  - After reset deasserts, `s_ready`=1 and all other outputs are 0.
- **Reset mid-operation (any state):** same effect; any partial load or pending result is discarded.
- **Decode:** write strobes and addresses are combinational from state, `cnt` and `s_valid`. The memory captures the word at the same edge the accept occurs.
- **Compute latency:**
  - The last vector word accepted in cycle t gives `mac_en` in cycles t+1..t+K and `m_valid` in cycle t+K+1.
  - Each later row starts COMPUTE in the cycle after its `m_ready` handshake and raises `m_valid` K cycles after entering COMPUTE.
- **Minimum throughput:** K+1 cycles per row result.
- **OUT, last row, `m_ready`=1:** next cycle is IDLE with `s_ready`=1. No input word is accepted in the handshake cycle itself.

## Test plan
- **Full load:** reset, then 20 consecutive words with `s_valid`=1 and `new_matrix`=1 on word 0 (K=4).
  - Required: `wr_en_m` on 16 cycles with `addr_m` 0..15, then `wr_en_x` on 4 cycles with `addr_x` 0..3.
  - Required: `mac_en` for 4 cycles, with `mac_clr` only on the first and `rd_col` 0..3.
  - Required: `m_valid` 5 cycles after the 20th accept; 4 results total, then IDLE.
- **Vector reuse:** second transaction of 4 words with `new_matrix`=0.
  - Required: no `wr_en_m` pulses, `wr_en_x` addr 0..3, and 4 results.
- **Forced matrix load:** immediately after reset, first word with `new_matrix`=0.
  - Required: the word goes to `addr_m`=0 and 16 matrix words are consumed before any vector write.
- **Input gaps:** `s_valid` toggled 1,0,1,0 through the load.
  - Required: write strobes only on accept cycles; addresses contiguous with no skips or repeats.
- **Output backpressure:** `m_ready`=0 for 10 cycles on row 1.
  - Required: `m_valid` held, `rd_row`=1 stable, `mac_en`=0, `s_ready`=0 throughout; rows 0..3 are each delivered exactly once.
- **Reset mid-run:** `reset` asserted for one cycle during COMPUTE row 2.
  - Required: next cycle IDLE, `m_valid`=0, `mac_en`=0, `s_ready`=1.
  - Required: a following `new_matrix`=0 transaction loads 16 matrix words.
